// File: rtl/audio_timing_pkg.sv
// Shared audio timing constants and slot FSM state encoding
// for the voice slot scheduler.
package audio_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } slot_state_e;

  localparam int SYS_CLK_HZ   = 32_000_000;
  localparam int CLK_DIV_48K  = 667;
  localparam int CLK_DIV_44K1 = 726;
  localparam int N_VOICES     = 37;

endpackage

// File: rtl/voice_slot_scheduler_if.sv
// Slot strobe handshake between the scheduler (master)
// and the voice engine (slave).
interface voice_slot_scheduler_if
  import audio_timing_pkg::*;
#(
  parameter int N_SLOTS = N_VOICES,
  parameter int SLOT_W  =
    (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
);

  logic               slot_valid;
  logic               slot_ready;
  logic [SLOT_W-1:0]  slot_idx;
  logic [N_SLOTS-1:0] events;

  modport master (
    output slot_valid,
    output slot_idx,
    output events,
    input  slot_ready
  );

  modport slave (
    input  slot_valid,
    input  slot_idx,
    input  events,
    output slot_ready
  );

endinterface

// File: rtl/voice_slot_scheduler_frame_counter.sv
// Frame cycle counter: period reload at wrap, wrap strobe
// and frame_start decode.
module frame_counter #(
  parameter int PERIOD_W = 10,
  parameter int CLK_DIV  = 667
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                wrap,
  output logic                frame_start
);

  logic                run;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] next_q;

  // zero would never wrap; fall back to the default
  assign next_q = (period == '0) ?
    PERIOD_W'(CLK_DIV) : period;

  assign wrap =
    run && (cnt == period_q - PERIOD_W'(1));
  assign frame_start = run && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      cnt      <= '0;
      period_q <= PERIOD_W'(CLK_DIV);
    end else if (!en) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (!run) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (wrap) begin
      cnt      <= '0;
      period_q <= next_q;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/voice_slot_scheduler.sv
// Per-frame voice slot strobe generator with valid/ready.
// VOICE_SLOT_PERIOD_PROG_EN adds the runtime period_i port.
module voice_slot_scheduler
  import audio_timing_pkg::*;
#(
  parameter int N_SLOTS     = N_VOICES,
  parameter int SLOT_W      =
    (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  parameter int PERIOD_W    = 10,
  parameter int CLK_DIV     = CLK_DIV_48K,
  parameter int SLOT_STRIDE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
`ifdef VOICE_SLOT_PERIOD_PROG_EN
  input  logic [PERIOD_W-1:0] period_i,
`endif
  input  logic                overrun_clr,
  output logic                frame_start,
  output logic                overrun,
  voice_slot_scheduler_if.master slot
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ISSUE);
  localparam logic [1:0] S_GAP   = 2'(GAP);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  localparam int GAP_W =
    (SLOT_STRIDE > 1) ? $clog2(SLOT_STRIDE) : 1;
  localparam logic [SLOT_W-1:0] LAST =
    SLOT_W'(N_SLOTS - 1);

  logic [1:0]          state;
  logic [SLOT_W-1:0]   idx;
  logic [GAP_W-1:0]    gap;
  logic [PERIOD_W-1:0] reload;
  logic                wrap;
  logic                valid;
  logic                xfer;
  logic                complete;

`ifdef VOICE_SLOT_PERIOD_PROG_EN
  assign reload = period_i;
`else
  assign reload = PERIOD_W'(CLK_DIV);
`endif

  frame_counter #(
    .PERIOD_W (PERIOD_W),
    .CLK_DIV  (CLK_DIV)
  ) u_fc (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .period      (reload),
    .wrap        (wrap),
    .frame_start (frame_start)
  );

  assign valid = (state == S_ISSUE);
  assign xfer  = valid && slot.slot_ready;
  // a last-slot transfer on the wrap cycle still completes
  assign complete = (state == S_DONE) ||
    (xfer && (idx == LAST));

  assign slot.slot_valid = valid;
  assign slot.slot_idx   = idx;
  assign slot.events     = valid ?
    (N_SLOTS'(1) << idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      gap   <= '0;
    end else if (!en) begin
      state <= S_IDLE;
      idx   <= '0;
    end else if (state == S_IDLE || wrap) begin
      state <= S_ISSUE;
      idx   <= '0;
    end else begin
      case (state)
        S_ISSUE: begin
          if (slot.slot_ready) begin
            if (idx == LAST) begin
              state <= S_DONE;
              idx   <= '0;
            end else begin
              idx <= idx + SLOT_W'(1);
              if (SLOT_STRIDE > 1) begin
                state <= S_GAP;
                gap   <= GAP_W'(SLOT_STRIDE - 1);
              end
            end
          end
        end
        S_GAP: begin
          if (gap == GAP_W'(1)) state <= S_ISSUE;
          else gap <= gap - GAP_W'(1);
        end
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (en && wrap && !complete) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_voice_slot_scheduler.sv
// Bench: three scheduler instances (default, period 40 stride 2,
// period 37) checked against a frame-position model.
module tb_voice_slot_scheduler;

  localparam int NS = 37;
  localparam int NI = 3;

  int per[NI]  = '{667, 40, 37};
  int strd[NI] = '{1, 2, 1};

  logic clk;
  logic rst;
  logic en[NI];
  logic rdy[NI];
  logic clr[NI];
`ifdef VOICE_SLOT_PERIOD_PROG_EN
  logic [9:0] pi[NI];
`endif

  logic          vv[NI];
  logic [5:0]    ix[NI];
  logic [NS-1:0] ev[NI];
  logic          fs[NI];
  logic          ov[NI];

  int checks = 0;
  int errors = 0;
  logic go = 0;
  logic d1 = 0;
  logic d2 = 0;

  voice_slot_scheduler_if #(.N_SLOTS(NS)) s0 ();
  voice_slot_scheduler_if #(.N_SLOTS(NS)) s1 ();
  voice_slot_scheduler_if #(.N_SLOTS(NS)) s2 ();

  assign s0.slot_ready = rdy[0];
  assign s1.slot_ready = rdy[1];
  assign s2.slot_ready = rdy[2];
  assign vv[0] = s0.slot_valid;
  assign vv[1] = s1.slot_valid;
  assign vv[2] = s2.slot_valid;
  assign ix[0] = s0.slot_idx;
  assign ix[1] = s1.slot_idx;
  assign ix[2] = s2.slot_idx;
  assign ev[0] = s0.events;
  assign ev[1] = s1.events;
  assign ev[2] = s2.events;

  voice_slot_scheduler #(
    .N_SLOTS(NS), .CLK_DIV(667), .SLOT_STRIDE(1)
  ) u0 (
    .clk(clk), .rst(rst), .en(en[0]),
`ifdef VOICE_SLOT_PERIOD_PROG_EN
    .period_i(pi[0]),
`endif
    .overrun_clr(clr[0]), .frame_start(fs[0]),
    .overrun(ov[0]), .slot(s0)
  );

  voice_slot_scheduler #(
    .N_SLOTS(NS), .CLK_DIV(40), .SLOT_STRIDE(2)
  ) u1 (
    .clk(clk), .rst(rst), .en(en[1]),
`ifdef VOICE_SLOT_PERIOD_PROG_EN
    .period_i(pi[1]),
`endif
    .overrun_clr(clr[1]), .frame_start(fs[1]),
    .overrun(ov[1]), .slot(s1)
  );

  voice_slot_scheduler #(
    .N_SLOTS(NS), .CLK_DIV(37), .SLOT_STRIDE(1)
  ) u2 (
    .clk(clk), .rst(rst), .en(en[2]),
`ifdef VOICE_SLOT_PERIOD_PROG_EN
    .period_i(pi[2]),
`endif
    .overrun_clr(clr[2]), .frame_start(fs[2]),
    .overrun(ov[2]), .slot(s2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // model: position in frame, next slot, earliest offer cycle
  int m_run[NI] = '{0, 0, 0};
  int m_t[NI]   = '{0, 0, 0};
  int m_k[NI]   = '{0, 0, 0};
  int m_nxt[NI] = '{0, 0, 0};
  int m_ov[NI]  = '{0, 0, 0};
  int m_pq[NI]  = '{667, 40, 37};

  function automatic bit mv(input int i);
    return m_run[i] != 0 && m_k[i] < NS &&
      m_t[i] >= m_nxt[i];
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    for (int i = 0; i < NI; i++) begin
      bit x;
      bit w;
      bit cmp;
      int rl;
      x = mv(i) && rdy[i];
      w = 0;
      cmp = 0;
      rl = per[i];
`ifdef VOICE_SLOT_PERIOD_PROG_EN
      if (pi[i] != 0) rl = int'(pi[i]);
`endif
      if (rst) begin
        m_run[i] = 0; m_t[i] = 0; m_k[i] = 0;
        m_nxt[i] = 0; m_ov[i] = 0; m_pq[i] = per[i];
        continue;
      end
      if (!en[i] || m_run[i] == 0) begin
        m_run[i] = en[i] ? 1 : 0;
        m_t[i] = 0; m_k[i] = 0; m_nxt[i] = 0;
      end else begin
        w = (m_t[i] == m_pq[i] - 1);
        cmp = (m_k[i] >= NS) || (x && m_k[i] == NS - 1);
        if (x) begin
          m_k[i]++;
          m_nxt[i] = m_t[i] + strd[i];
        end
        if (w) begin
          m_t[i] = 0; m_k[i] = 0; m_nxt[i] = 0;
          m_pq[i] = rl;
        end else begin
          m_t[i]++;
        end
      end
      if (w && !cmp) m_ov[i] = 1;
      else if (clr[i]) m_ov[i] = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        bit v;
        logic [63:0] e;
        v = mv(i);
        e = v ? (64'd1 << m_k[i]) : 64'd0;
        chk($sformatf("m%0d valid", i), vv[i], v);
        chk($sformatf("m%0d events", i), ev[i], e);
        chk($sformatf("m%0d fstart", i), fs[i],
            m_run[i] != 0 && m_t[i] == 0);
        chk($sformatf("m%0d overrun", i), ov[i],
            m_ov[i] != 0);
        if (v) chk($sformatf("m%0d idx", i), ix[i], m_k[i]);
      end
    end
  end

  task automatic wait_fs(input int i, output int n);
    n = 0;
    while (n < 2000) begin
      step(1);
      n++;
      if (fs[i]) break;
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // period 40, stride 2: frame always overruns
  initial begin
    wait (go);
    step(1);
    chk("i1 slot0", {vv[1], ix[1]}, {1'b1, 6'd0});
    step(38);
    chk("i1 slot19", {vv[1], ix[1]}, {1'b1, 6'd19});
    step(1);
    chk("i1 gap", vv[1], 0);
    step(1);
    chk("i1 wrap ov", {ov[1], fs[1], ix[1]},
        {1'b1, 1'b1, 6'd0});
    clr[1] = 1;
    step(1);
    chk("i1 clr", ov[1], 0);
    clr[1] = 0;
    step(38);
    clr[1] = 1;
    step(1);
    chk("i1 set wins", {ov[1], fs[1]}, 2'b11);
    clr[1] = 0;
    d1 = 1;
  end

  // period 37: last slot coincides with wrap
  initial begin
    wait (go);
    step(1);
    chk("i2 slot0", {vv[2], ix[2]}, {1'b1, 6'd0});
    step(36);
    chk("i2 slot36", {vv[2], ix[2]}, {1'b1, 6'd36});
    step(1);
    chk("i2 next frame", {fs[2], vv[2], ix[2], ov[2]},
        {1'b1, 1'b1, 6'd0, 1'b0});
    step(111);
    chk("i2 no ov", {fs[2], ov[2]}, 2'b10);
    d2 = 1;
  end

  initial begin
    int n;
    rst = 1;
    for (int i = 0; i < NI; i++) begin
      en[i] = 0; rdy[i] = 1; clr[i] = 0;
`ifdef VOICE_SLOT_PERIOD_PROG_EN
      pi[i] = 0;
`endif
    end
`ifdef VOICE_SLOT_PERIOD_PROG_EN
    pi[0] = 10'd667;
`endif
    step(2);
    chk("reset out", {vv[0], ev[0], fs[0], ov[0]}, 0);
    rst = 0;
    step(2);
    chk("idle out", {vv[0], ev[0], fs[0]}, 0);
    for (int i = 0; i < NI; i++) en[i] = 1;
    go = 1;
    step(1);
    chk("fs cnt0", {fs[0], ev[0]}, {1'b1, 37'd1});
    step(30);
    chk("ev bit30", ev[0], 64'h4000_0000);
    step(7);
    chk("done cnt37", {vv[0], ev[0]}, 0);
    wait_fs(0, n);
    chk("frame2 gap", n, 630);
    step(5);
    chk("slot5", ix[0], 5);
    rdy[0] = 0;
    for (int j = 0; j < 10; j++) begin
      step(1);
      chk("hold5", {vv[0], ix[0]}, {1'b1, 6'd5});
    end
    rdy[0] = 1;
    step(1);
    chk("slot6", {vv[0], ix[0]}, {1'b1, 6'd6});
    wait_fs(0, n);
    chk("stall frame", n, 651);
    step(12);
    chk("slot12", ix[0], 12);
    en[0] = 0;
    step(1);
    chk("en low", {vv[0], ix[0], ev[0], fs[0]}, 0);
    en[0] = 1;
    step(1);
    chk("re-en", {fs[0], vv[0], ix[0]},
        {1'b1, 1'b1, 6'd0});
`ifdef VOICE_SLOT_PERIOD_PROG_EN
    wait_fs(0, n);
    chk("prog f0", n, 667);
    step(100);
    pi[0] = 10'd726;
    wait_fs(0, n);
    chk("prog cur", n, 567);
    wait_fs(0, n);
    chk("prog new", n, 726);
`endif
    n = 0;
    while (!(d1 && d2) && n < 5000) begin
      step(1);
      n++;
    end
    chk("sub done", d1 && d2, 1);
    step(20);
    rst = 1;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("async rst%0d", i),
          {vv[i], ev[i], fs[i], ov[i]}, 0);
    step(2);
    rst = 0;
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
